// File: rtl/linear_layer_q_srl_fifo_ctrl.sv
// First-word-fall-through FIFO controller: SRL storage array plus a registered
// output stage with bypass, giving one-cycle producer-to-consumer latency.
module linear_layer_q_srl_fifo_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap
);

  localparam int unsigned SRL_N = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CAP_C   = (ADDR_WIDTH + 1)'(DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

  // Storage is sized to the full address space so every read address is in range.
  logic [SRL_N-1:0][DATA_WIDTH-1:0] srl;
  logic [ADDR_WIDTH:0]              cnt;
  logic                             out_valid;
  logic [DATA_WIDTH-1:0]            out_data;

  logic                  push;
  logic                  rd;
  logic                  load;
  logic                  we;
  logic                  cnt_zero;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] srl_q;

  always_comb begin
    cnt_zero  = (cnt == '0);
    if_full_n = (cnt != DEPTH_C);
    push      = if_write & if_write_ce & if_full_n;
    rd        = if_read & if_read_ce & out_valid;
    load      = ~out_valid | rd;
    // A push while the SRL is non-empty always lands in the SRL; the bypass
    // only applies when the SRL holds nothing.
    we        = push & ~reset & ~(load & cnt_zero);
    raddr     = cnt_zero ? '0 : ADDR_WIDTH'(cnt - CNT_ONE);
    srl_q     = srl[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      srl <= {srl[SRL_N-2:0], if_din};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      if (cnt_zero) begin
        if (push) begin
          out_data  <= if_din;
          out_valid <= 1'b1;
        end else if (rd) begin
          out_valid <= 1'b0;
        end
      end else begin
        // Refill with a concurrent push: the shift moves the consumed word
        // past cnt-1, so cnt stays put and order is preserved.
        out_data  <= srl_q;
        out_valid <= 1'b1;
        if (!push) begin
          cnt <= cnt - CNT_ONE;
        end
      end
    end else if (push) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  always_comb begin
    if_empty_n        = out_valid;
    if_dout           = out_data;
    if_num_data_valid = cnt + {{ADDR_WIDTH{1'b0}}, out_valid};
    if_fifo_cap       = CAP_C;
  end

endmodule

// File: tb/tb_linear_layer_q_srl_fifo_ctrl.sv
// Self-checking bench: directed vector table followed by randomized traffic
// compared against a queue-based FIFO reference model.
module tb_linear_layer_q_srl_fifo_ctrl;

  localparam int DW  = 128;
  localparam int AW  = 2;
  localparam int DEP = 2;
  localparam int CAP = DEP + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_write_ce, if_write, if_read_ce, if_read;
  logic [DW-1:0] if_din;
  logic          if_full_n, if_empty_n;
  logic [DW-1:0] if_dout;
  logic [AW:0]   if_num_data_valid, if_fifo_cap;

  int total = 0;
  int bad   = 0;

  linear_layer_q_srl_fifo_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH(DEP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_write_ce(if_write_ce),
    .if_write(if_write),
    .if_din(if_din),
    .if_full_n(if_full_n),
    .if_read_ce(if_read_ce),
    .if_read(if_read),
    .if_dout(if_dout),
    .if_empty_n(if_empty_n),
    .if_num_data_valid(if_num_data_valid),
    .if_fifo_cap(if_fifo_cap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          w;
    logic          r;
    logic [DW-1:0] din;
    logic          e_n;
    logic          f_n;
    int            n;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rst, logic w, logic r, logic [DW-1:0] din,
                              logic e_n, logic f_n, int n, logic [DW-1:0] dout);
    vec_t v;
    v.rst = rst; v.w = w; v.r = r; v.din = din;
    v.e_n = e_n; v.f_n = f_n; v.n = n; v.dout = dout;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, int idx, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive_cycle(logic rst, logic wce, logic w, logic [DW-1:0] din,
                             logic rce, logic r);
    reset = rst; if_write_ce = wce; if_write = w; if_din = din;
    if_read_ce = rce; if_read = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(int idx, logic e_n, logic f_n, int n, logic [DW-1:0] dout);
    chk("empty_n", idx, DW'(if_empty_n), DW'(e_n));
    chk("full_n",  idx, DW'(if_full_n),  DW'(f_n));
    chk("count",   idx, DW'(if_num_data_valid), DW'(n));
    chk("dout",    idx, if_dout, dout);
    chk("cap",     idx, DW'(if_fifo_cap), DW'(CAP));
  endtask

  // Reference model: a word queue plus the last value shown on the output.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] mdout;

  initial begin
    reset = 1'b1; if_write_ce = 1'b0; if_write = 1'b0; if_din = '0;
    if_read_ce = 1'b0; if_read = 1'b0;
    #1;

    // Columns: rst w r din | empty_n full_n count dout
    add(1, 0, 0, 'h00, 0, 1, 0, 'h00);
    add(0, 0, 0, 'h00, 0, 1, 0, 'h00);
    add(0, 0, 0, 'h00, 0, 1, 0, 'h00);
    add(0, 0, 0, 'h00, 0, 1, 0, 'h00);
    add(0, 1, 0, 'hA1, 1, 1, 1, 'hA1);
    add(0, 0, 1, 'h00, 0, 1, 0, 'hA1);
    add(0, 1, 0, 'h01, 1, 1, 1, 'h01);
    add(0, 1, 0, 'h02, 1, 1, 2, 'h01);
    add(0, 1, 0, 'h03, 1, 0, 3, 'h01);
    add(0, 1, 0, 'h04, 1, 0, 3, 'h01);
    add(0, 1, 1, 'h04, 1, 1, 2, 'h02);
    add(0, 1, 1, 'h04, 1, 1, 2, 'h03);
    add(0, 0, 1, 'h00, 1, 1, 1, 'h04);
    add(0, 0, 1, 'h00, 0, 1, 0, 'h04);
    for (int i = 0; i < 16; i++) begin
      add(0, 1, 1, DW'(32'h10 + i), 1, 1, 1, DW'(32'h10 + i));
    end
    add(0, 1, 0, 'h20, 1, 1, 2, 'h1F);
    add(0, 1, 1, 'h55, 1, 1, 2, 'h20);
    add(0, 0, 1, 'h00, 1, 1, 1, 'h55);
    add(0, 0, 1, 'h00, 0, 1, 0, 'h55);
    add(0, 1, 0, 'h61, 1, 1, 1, 'h61);
    add(0, 1, 0, 'h62, 1, 1, 2, 'h61);
    add(0, 1, 0, 'h63, 1, 0, 3, 'h61);
    add(1, 1, 0, 'h77, 0, 1, 0, 'h00);
    add(0, 1, 0, 'h88, 1, 1, 1, 'h88);
    add(0, 0, 1, 'h00, 0, 1, 0, 'h88);

    foreach (vecs[i]) begin
      drive_cycle(vecs[i].rst, 1'b1, vecs[i].w, vecs[i].din, 1'b1, vecs[i].r);
      chk_all(i, vecs[i].e_n, vecs[i].f_n, vecs[i].n, vecs[i].dout);
    end

    // Clock-enable masking: held writes/reads with ce low must have no effect.
    drive_cycle(0, 0, 1, 'h99, 1, 0);
    chk_all(1000, 0, 1, 0, 'h88);
    drive_cycle(0, 1, 1, 'h9A, 1, 0);
    chk_all(1001, 1, 1, 1, 'h9A);
    drive_cycle(0, 0, 0, 'h00, 0, 1);
    chk_all(1002, 1, 1, 1, 'h9A);

    // Randomized traffic against the reference model.
    mq.delete();
    mdout = '0;
    drive_cycle(1, 0, 0, '0, 0, 0);
    chk_all(2000, 0, 1, 0, '0);
    for (int k = 0; k < 3000; k++) begin
      logic          rst, wce, w, rce, r, acc_push, acc_pop;
      logic [DW-1:0] din;
      rst = ($urandom_range(63) == 0);
      wce = ($urandom_range(7) != 0);
      rce = ($urandom_range(7) != 0);
      w   = ($urandom_range(3) != 0);
      r   = (k < 1500) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      din = {$urandom, $urandom, $urandom, $urandom};
      acc_push = w & wce & (mq.size() < CAP);
      acc_pop  = r & rce & (mq.size() > 0);
      drive_cycle(rst, wce, w, din, rce, r);
      if (rst) begin
        mq.delete();
        mdout = '0;
      end else begin
        if (acc_pop) void'(mq.pop_front());
        if (acc_push) mq.push_back(din);
        if (mq.size() > 0) mdout = mq[0];
      end
      chk_all(3000 + k, mq.size() > 0, mq.size() < CAP, mq.size(), mdout);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
